// File: rtl/lane_shift_reg.sv
// Lane-loadable WIDTH-bit datapath register with a multi-cycle shift/rotate engine.
// A start request runs 'amount' one-bit steps, then done pulses for one cycle.
module lane_shift_reg #(
   parameter int WIDTH = 32,
   parameter int LANE  = 4,
   parameter int CNTW  = 5
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load,
   input  logic [WIDTH/LANE-1:0]   lane_en,
   input  logic [WIDTH-1:0]        d,
   input  logic                    start,
   input  logic [1:0]              op,
   input  logic [CNTW-1:0]         amount,
   input  logic                    sin,
   output logic [WIDTH-1:0]        q,
   output logic                    sout,
   output logic                    busy,
   output logic                    done
);

   localparam int NL = WIDTH / LANE;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t            state;
   logic [CNTW-1:0]   cnt;
   logic [1:0]        op_q;
   logic [WIDTH-1:0]  load_val;
   logic [WIDTH-1:0]  step_q;
   logic              step_out;

   // Lanes without an enable recirculate their current contents.
   for (genvar i = 0; i < NL; i++) begin : g_lane
      assign load_val[i*LANE +: LANE] = lane_en[i] ? d[i*LANE +: LANE] : q[i*LANE +: LANE];
   end

   always_comb begin
      step_q   = q;
      step_out = sout;
      case (op_q)
         2'b00: begin step_q = {q[WIDTH-2:0], sin};        step_out = q[WIDTH-1]; end
         2'b01: begin step_q = {sin, q[WIDTH-1:1]};        step_out = q[0];       end
         2'b10: begin step_q = {q[WIDTH-2:0], q[WIDTH-1]}; step_out = q[WIDTH-1]; end
         default: begin step_q = {q[0], q[WIDTH-1:1]};     step_out = q[0];       end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
         op_q  <= 2'b00;
         q     <= '0;
         sout  <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               // Load has priority; a simultaneous start is dropped.
               if (load) begin
                  q <= load_val;
               end else if (start) begin
                  op_q <= op;
                  cnt  <= amount;
                  if (amount == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= SHIFT;
                     busy  <= 1'b1;
                  end
               end
            end
            SHIFT: begin
               q    <= step_q;
               sout <= step_out;
               cnt  <= cnt - CNTW'(1);
               // cnt is at least 1 here, so the decrement cannot wrap.
               if (cnt == CNTW'(1)) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lane_shift_reg.sv
// Directed bench for lane_shift_reg: lane loads, shifts/rotates, priority, zero amount,
// ignored mid-operation requests and asynchronous abort.
module tb_lane_shift_reg;

   logic        clk = 1'b0;
   logic        reset;
   logic        load;
   logic [7:0]  lane_en;
   logic [31:0] d;
   logic        start;
   logic [1:0]  op;
   logic [4:0]  amount;
   logic        sin;
   logic [31:0] q;
   logic        sout;
   logic        busy;
   logic        done;

   int total = 0;
   int bad   = 0;
   int bcnt;
   bit got_done;
   bit saw_done;

   lane_shift_reg #(.WIDTH(32), .LANE(4), .CNTW(5)) dut (
      .clk(clk), .reset(reset), .load(load), .lane_en(lane_en), .d(d),
      .start(start), .op(op), .amount(amount), .sin(sin),
      .q(q), .sout(sout), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_load(input logic [31:0] val, input logic [7:0] en);
      load = 1'b1; d = val; lane_en = en;
      tick();
      load = 1'b0;
   endtask

   // Starts an operation and waits (bounded) for done, counting busy cycles.
   task automatic run(input logic [1:0] o, input logic [4:0] k, input bit disturb,
                      output int bc, output bit gd);
      start = 1'b1; op = o; amount = k;
      tick();
      start = 1'b0;
      amount = ~k;
      bc = 0;
      gd = 1'b0;
      for (int i = 0; i < 100 && !gd; i++) begin
         if (busy) bc++;
         if (done) gd = 1'b1;
         else begin
            if (disturb && bc == 2) begin
               load = 1'b1; start = 1'b1; d = 32'h0; lane_en = 8'hFF; op = ~o; amount = 5'd1;
            end else begin
               load = 1'b0; start = 1'b0;
            end
            tick();
         end
      end
      load = 1'b0; start = 1'b0;
   endtask

   initial begin
      reset = 1'b0; load = 1'b0; lane_en = '0; d = '0; start = 1'b0;
      op = 2'b00; amount = '0; sin = 1'b0;
      repeat (3) tick();
      chk("rst_q", q, 32'h0);
      chk("rst_sout", {31'b0, sout}, 32'h0);
      chk("rst_busy", {31'b0, busy}, 32'h0);
      chk("rst_done", {31'b0, done}, 32'h0);
      reset = 1'b1;
      repeat (2) tick();
      chk("post_rst_q", q, 32'h0);
      chk("post_rst_busy", {31'b0, busy}, 32'h0);

      do_load(32'hFFFF_FFFF, 8'hFF);
      chk("load_all", q, 32'hFFFF_FFFF);
      do_load(32'hAFAF_AFAF, 8'h0F);
      chk("load_lanes", q, 32'hFFFF_AFAF);

      sin = 1'b0;
      run(2'b00, 5'd4, 1'b0, bcnt, got_done);
      chk("sll_done", {31'b0, got_done}, 32'h1);
      chk("sll_busycnt", bcnt, 32'd4);
      chk("sll_q", q, 32'hFFFA_FAF0);
      chk("sll_sout", {31'b0, sout}, 32'h1);
      chk("sll_busy_at_done", {31'b0, busy}, 32'h0);
      tick();
      chk("sll_done_pulse", {31'b0, done}, 32'h0);
      chk("sll_q_hold", q, 32'hFFFA_FAF0);

      do_load(32'h1234_5678, 8'hFF);
      chk("load_sout_hold", {31'b0, sout}, 32'h1);
      run(2'b11, 5'd8, 1'b0, bcnt, got_done);
      chk("ror8_busycnt", bcnt, 32'd8);
      chk("ror8_q", q, 32'h7812_3456);
      chk("ror8_sout", {31'b0, sout}, 32'h0);
      tick();
      run(2'b11, 5'd31, 1'b0, bcnt, got_done);
      chk("ror31_busycnt", bcnt, 32'd31);
      tick();
      run(2'b11, 5'd1, 1'b0, bcnt, got_done);
      chk("ror32_q", q, 32'h7812_3456);
      tick();

      // load and start together: only the load happens
      load = 1'b1; start = 1'b1; d = 32'hDEAD_BEEF; lane_en = 8'hFF; op = 2'b00; amount = 5'd3;
      tick();
      load = 1'b0; start = 1'b0;
      chk("prio_q", q, 32'hDEAD_BEEF);
      chk("prio_busy", {31'b0, busy}, 32'h0);
      tick();
      chk("prio_busy2", {31'b0, busy}, 32'h0);
      chk("prio_done2", {31'b0, done}, 32'h0);

      start = 1'b1; op = 2'b10; amount = 5'd0;
      tick();
      start = 1'b0;
      chk("zero_done", {31'b0, done}, 32'h1);
      chk("zero_busy", {31'b0, busy}, 32'h0);
      chk("zero_q", q, 32'hDEAD_BEEF);
      tick();
      chk("zero_done_off", {31'b0, done}, 32'h0);

      do_load(32'h0F0F_0F0F, 8'hFF);
      run(2'b10, 5'd4, 1'b1, bcnt, got_done);
      chk("dist_busycnt", bcnt, 32'd4);
      chk("dist_q", q, 32'hF0F0_F0F0);
      chk("dist_sout", {31'b0, sout}, 32'h0);
      tick();

      do_load(32'hA5A5_A5A5, 8'hFF);
      start = 1'b1; op = 2'b01; amount = 5'd10;
      tick();
      start = 1'b0;
      tick();
      chk("abort_busy_pre", {31'b0, busy}, 32'h1);
      #2 reset = 1'b0;
      #1;
      chk("abort_q", q, 32'h0);
      chk("abort_busy", {31'b0, busy}, 32'h0);
      chk("abort_done", {31'b0, done}, 32'h0);
      tick();
      reset = 1'b1;
      saw_done = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (done || busy) saw_done = 1'b1;
      end
      chk("abort_no_done", {31'b0, saw_done}, 32'h0);
      chk("abort_q_after", q, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lane_shift_reg.md
Name: lane_shift_reg

Overview:
- Parametrised successor to the team's fixed 32-bit, 4-bit-sliced register.
- Holds a WIDTH-bit word split into LANE-bit lanes, each lane loadable on its own.
- Adds a multi-cycle shift/rotate engine: a start/busy/done handshake runs the requested number of one-bit steps.
- Sits as a general datapath register in front of ALU/serial blocks.

Parameters:
WIDTH, 32, register width in bits; must be a multiple of LANE.
LANE, 4, lane width in bits; lane count NL = WIDTH/LANE.
CNTW, 5, width of the shift-amount field; maximum shift is 2^CNTW-1.

Ports:
clk  in  1  clock; all state updates on posedge.
reset  in  1  asynchronous, active-low reset.
load  in  1  parallel-load request; sampled in IDLE only.
lane_en  in  NL  per-lane load enable; bit i covers q[i*LANE+LANE-1 : i*LANE].
d  in  WIDTH  parallel load data.
start  in  1  shift-operation request; sampled in IDLE only.
op  in  2  00 shift left logical, 01 shift right logical, 10 rotate left, 11 rotate right.
amount  in  CNTW  number of one-bit steps.
sin  in  1  serial fill bit for logical shifts; sampled live on every step.
q  out  WIDTH  register contents.
sout  out  1  last bit shifted or rotated out.
busy  out  1  high while shifting.
done  out  1  one-cycle completion pulse.

Behaviour:
- Reset low, asynchronous: q=0, sout=0, busy=0, done=0, state=IDLE, step counter=0, latched op=00. Takes effect immediately without a clock edge, including mid-operation; the operation in progress is aborted and never completes.
- States: IDLE, SHIFT, DONE. All outputs are registered.
- IDLE, load=1 at a clock edge:
  - Each lane with lane_en[i]=1 takes d's lane; lanes with lane_en[i]=0 hold.
  - sout holds.
  - State stays IDLE.
- IDLE, load=1 and start=1 in the same cycle: load wins; start is dropped, not queued.
- IDLE, start=1, load=0, amount=0: q unchanged; next state DONE; busy stays 0.
- IDLE, start=1, load=0, amount=k>0: latch op and k; next state SHIFT; busy=1 from the following cycle.
- SHIFT, each edge, performs one step:
  - op 00: q <= {q[WIDTH-2:0], sin}; sout <= q[WIDTH-1].
  - op 01: q <= {sin, q[WIDTH-1:1]}; sout <= q[0].
  - op 10: q <= {q[WIDTH-2:0], q[WIDTH-1]}; sout <= q[WIDTH-1].
  - op 11: q <= {q[0], q[WIDTH-1:1]}; sout <= q[0].
  - Counter decrements; when it reaches 0 the next state is DONE.
  - Exactly k steps run, so busy is high for exactly k cycles.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- Latency: done is high in cycle k+1 after the start edge; for k=0, in the cycle right after.
- q holds its final value from the done cycle until the next load or shift.
- While in SHIFT or DONE, load, start, op, amount, d and lane_en are ignored.
- Rotates wrap around with no bit lost; after k = WIDTH rotate steps, q equals its original value.
- Counter never underflows. amount is latched, so changing it mid-operation has no effect.

Test Plan:
- Reset: hold reset=0 while clk toggles -> q=0, sout=0, busy=0, done=0. Release -> all stay 0 until a load.
- Lane load (WIDTH=32, LANE=4):
  - load d=FFFFFFFF, lane_en=FF -> q=FFFFFFFF.
  - Then load d=AFAFAFAF, lane_en=0F -> q=FFFFAFAF.
- Shift left: q=FFFFAFAF, start, op=00, amount=4, sin=0 -> busy high for 4 cycles, done pulse on the 5th cycle, q=FFFAFAF0, sout=1.
- Rotate right: q=12345678, start, op=11, amount=8 -> q=78123456, sout=0, busy for 8 cycles. A second run with amount=31, then one with amount=1, -> q back to 78123456.
- Priority and zero amount:
  - load and start in the same cycle -> only the load occurs, busy stays 0.
  - start with amount=0 -> done in the next cycle, busy never rises, q unchanged.
- Abort and ignored requests:
  - start and load pulsed during busy -> ignored, result identical to an undisturbed run.
  - reset driven low mid-SHIFT between clock edges -> q=0, busy=0 immediately; no done pulse after release.
